// File: rtl/mem_reinit_ctrl.sv
// Reinitialises one block-RAM from an init source: FILL sweep, optional VERIFY read-back,
// and arbitration of the memory port pair between the sweep engine and the user port.
//
// state    | meaning
// S_IDLE   | user port owns the memory; waits for start
// S_FILL   | copies init source into memory, one word per cycle plus one drain cycle
// S_VERIFY | reads memory back and compares against init source
// S_DONE   | one-cycle completion pulse
module mem_reinit_ctrl #(
  parameter int WID_MEM   = 32,
  parameter int DEPTH_MEM = 1024,
  parameter int ADDR_W    = 32,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               verify_en,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [CNT_W-1:0]   mis_cnt,
  output logic [ADDR_W-1:0]  first_bad,
  output logic [ADDR_W-1:0]  src_addr,
  input  logic [WID_MEM-1:0] src_data,
  input  logic               u_we,
  input  logic [ADDR_W-1:0]  u_waddr,
  input  logic [WID_MEM-1:0] u_din,
  output logic               u_ready,
  input  logic               u_re,
  input  logic [ADDR_W-1:0]  u_raddr,
  output logic               u_rvalid,
  output logic [WID_MEM-1:0] u_dout,
  output logic [ADDR_W-1:0]  m_raddr,
  output logic [ADDR_W-1:0]  m_waddr,
  output logic [WID_MEM-1:0] m_din,
  output logic               m_we,
  input  logic [WID_MEM-1:0] m_dout
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH_MEM - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_VERIFY, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] pend_addr;
  logic              pend;
  logic              drain;
  logic              verify_q;
  logic              rvalid_q;
  logic              idle_on;
  logic              fill_wr;

  // idle_on includes reset so the user path stays quiet while reset is held
  always_comb begin
    state_nxt = state;
    idle_on   = reset && (state == S_IDLE);
    fill_wr   = (state == S_FILL) && pend;
    busy      = (state == S_FILL) || (state == S_VERIFY);
    done      = (state == S_DONE);
    u_ready   = idle_on;
    u_rvalid  = rvalid_q && (state == S_IDLE);
    u_dout    = idle_on ? m_dout : '0;
    src_addr  = idx;
    m_we      = idle_on ? u_we : fill_wr;
    m_waddr   = idle_on ? u_waddr : (fill_wr ? pend_addr : '0);
    m_din     = idle_on ? u_din : (fill_wr ? src_data : '0);
    m_raddr   = idle_on ? u_raddr : ((state == S_VERIFY) ? idx : '0);
    case (state)
      S_IDLE:   if (start) state_nxt = S_FILL;
      S_FILL:   if (drain) state_nxt = verify_q ? S_VERIFY : S_DONE;
      S_VERIFY: if (drain) state_nxt = S_DONE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      pend_addr <= '0;
      pend      <= 1'b0;
      drain     <= 1'b0;
      verify_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      err       <= 1'b0;
      mis_cnt   <= '0;
      first_bad <= '0;
    end else begin
      state    <= state_nxt;
      rvalid_q <= (state == S_IDLE) && u_re;
      case (state)
        S_IDLE: begin
          if (start) begin
            idx       <= '0;
            pend      <= 1'b0;
            drain     <= 1'b0;
            verify_q  <= verify_en;
            err       <= 1'b0;
            mis_cnt   <= '0;
            first_bad <= '0;
          end
        end
        S_FILL, S_VERIFY: begin
          // pend/pend_addr carry last cycle's index: write slot in FILL, compare slot in VERIFY
          if ((state == S_VERIFY) && pend && (m_dout != src_data)) begin
            err <= 1'b1;
            if (mis_cnt != '1) mis_cnt <= mis_cnt + CNT_W'(1);
            if (!err) first_bad <= pend_addr;
          end
          if (drain) begin
            idx   <= '0;
            pend  <= 1'b0;
            drain <= 1'b0;
          end else begin
            pend      <= 1'b1;
            pend_addr <= idx;
            if (idx == LAST_IDX) drain <= 1'b1;
            else idx <= idx + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
